// File: rtl/imm_pkg.sv
// Shared format codes, opcode constants and the pure decode/extend helpers
// for the pipelined immediate generator.
package imm_pkg;

    localparam logic [2:0] FMT_I   = 3'b000;
    localparam logic [2:0] FMT_S   = 3'b001;
    localparam logic [2:0] FMT_B   = 3'b010;
    localparam logic [2:0] FMT_J   = 3'b011;
    localparam logic [2:0] FMT_U   = 3'b100;
    localparam logic [2:0] FMT_Z   = 3'b101;
    localparam logic [2:0] FMT_SH  = 3'b110;
    localparam logic [2:0] FMT_ILL = 3'b111;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    function automatic logic [2:0] decode_fmt(input logic [31:0] instr);
        logic [2:0] f3;
        logic [2:0] fmt;
        f3  = instr[14:12];
        fmt = FMT_ILL;
        case (instr[6:0])
            OP_IMM:             fmt = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SH : FMT_I;
            OP_LOAD, OP_JALR:   fmt = FMT_I;
            OP_STORE:           fmt = FMT_S;
            OP_BRANCH:          fmt = FMT_B;
            OP_JAL:             fmt = FMT_J;
            OP_LUI, OP_AUIPC:   fmt = FMT_U;
            OP_SYSTEM:          fmt = f3[2] ? FMT_Z : FMT_I;
            default:            fmt = FMT_ILL;
        endcase
        return fmt;
    endfunction

    // Always produces a 64-bit result; narrower datapaths keep the low bits,
    // which is still correct for every sign-extended format.
    function automatic logic [63:0] extend(input logic [2:0] fmt, input logic [31:0] instr,
                                           input int xlen);
        logic [63:0] r;
        r = '0;
        case (fmt)
            FMT_I:  r = {{52{instr[31]}}, instr[31:20]};
            FMT_S:  r = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:  r = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_J:  r = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_U:  r = {{32{instr[31]}}, instr[31:12], 12'b0};
            FMT_Z:  r = {59'b0, instr[19:15]};
            FMT_SH: r = (xlen == 32) ? {59'b0, instr[24:20]} : {58'b0, instr[25:20]};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_fmt_decode.sv
// Combinational opcode/funct3 to immediate-format decoder.
module imm_fmt_decode
    import imm_pkg::*;
(
    input  logic [31:0] instr,
    output logic [2:0]  fmt
);

    logic unused_bits;

    assign fmt         = decode_fmt(instr);
    assign unused_bits = ^{instr[31:15], instr[11:7]};

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage pipelined immediate generator with valid/ready handshake,
// per-beat illegal-format flag and a saturating illegal-format counter.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int AUTO_DECODE = 0,
    parameter int TAG_W       = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr_cnt
);

    logic [2:0]       in_fmt;
    logic             s1_valid;
    logic [31:0]      s1_instr;
    logic [2:0]       s1_fmt;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_load;
    logic             s2_load;
    logic [63:0]      ext_full;
    logic             unused_op;

    generate
        if (AUTO_DECODE != 0) begin : g_auto
            logic unused_src;
            assign unused_src = ^imm_src;
            imm_fmt_decode u_dec (
                .instr (instr),
                .fmt   (in_fmt)
            );
        end else begin : g_ext
            assign in_fmt = imm_src;
        end
    endgenerate

    // Handshake: a beat transfers on a rising edge where valid && ready. A
    // producer holds valid and payload stable until it transfers; ready never
    // looks at the same-side valid, so in_ready depends on out_ready only.
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_instr <= '0;
            s1_fmt   <= FMT_I;
            s1_tag   <= '0;
        end else if (s1_load && in_valid) begin
            s1_instr <= instr;
            s1_fmt   <= in_fmt;
            s1_tag   <= in_tag;
        end
    end

    assign ext_full  = extend(s1_fmt, s1_instr, XLEN);
    assign unused_op = ^s1_instr[6:0];

    generate
        if (XLEN < 64) begin : g_trunc
            logic unused_hi;
            assign unused_hi = ^ext_full[63:XLEN];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
        end
    end

    // Payload only moves with a real beat, so a stall or bubble leaves it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imm     <= '0;
            out_fmt <= FMT_I;
            out_tag <= '0;
            out_err <= 1'b0;
        end else if (s2_load && s1_valid) begin
            imm     <= ext_full[XLEN-1:0];
            out_fmt <= s1_fmt;
            out_tag <= s1_tag;
            out_err <= (s1_fmt == FMT_ILL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && out_err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit external-format instance and a
// 64-bit auto-decode instance share the input stream and are checked side by side.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        clr_cnt;
    logic [31:0] instr;
    logic [2:0]  imm_src;
    logic [3:0]  in_tag;

    logic        m_in_ready, m_out_valid, m_out_err;
    logic [31:0] m_imm;
    logic [2:0]  m_out_fmt;
    logic [3:0]  m_out_tag;
    logic [7:0]  m_err_cnt;

    logic        a_in_ready, a_out_valid, a_out_err;
    logic [63:0] a_imm;
    logic [2:0]  a_out_fmt;
    logic [3:0]  a_out_tag;
    logic [1:0]  a_err_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0), .TAG_W(4), .CNT_W(8)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
        .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(m_out_valid), .out_ready(out_ready), .imm(m_imm),
        .out_fmt(m_out_fmt), .out_tag(m_out_tag), .out_err(m_out_err),
        .err_cnt(m_err_cnt), .clr_cnt(clr_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1), .TAG_W(4), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .instr(instr), .imm_src(imm_src), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready), .imm(a_imm),
        .out_fmt(a_out_fmt), .out_tag(a_out_tag), .out_err(a_out_err),
        .err_cnt(a_err_cnt), .clr_cnt(clr_cnt)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver: one beat with out_ready high, returns when its result is visible
    task automatic beat(input logic [31:0] ins, input logic [2:0] src, input logic [3:0] tag);
        instr    = ins;
        imm_src  = src;
        in_tag   = tag;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic check_out(input string name,
                             input logic [31:0] m_exp, input logic [2:0] m_fmt,
                             input logic [63:0] a_exp, input logic [2:0] a_fmt,
                             input logic [3:0]  tag);
        chk({name, "/m_valid"}, 64'(m_out_valid), 64'd1);
        chk({name, "/m_imm"},   64'(m_imm),       64'(m_exp));
        chk({name, "/m_fmt"},   64'(m_out_fmt),   64'(m_fmt));
        chk({name, "/m_err"},   64'(m_out_err),   64'(m_fmt == 3'b111));
        chk({name, "/m_tag"},   64'(m_out_tag),   64'(tag));
        chk({name, "/a_valid"}, 64'(a_out_valid), 64'd1);
        chk({name, "/a_imm"},   a_imm,            a_exp);
        chk({name, "/a_fmt"},   64'(a_out_fmt),   64'(a_fmt));
        chk({name, "/a_err"},   64'(a_out_err),   64'(a_fmt == 3'b111));
        chk({name, "/a_tag"},   64'(a_out_tag),   64'(tag));
    endtask

    initial begin
        logic accepted;
        int   next_tag;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        instr     = '0;
        imm_src   = '0;
        in_tag    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst/m_in_ready",  64'(m_in_ready),  64'd1);
        chk("rst/a_in_ready",  64'(a_in_ready),  64'd1);
        chk("rst/m_out_valid", 64'(m_out_valid), 64'd0);
        chk("rst/a_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst/a_imm",       a_imm,            64'd0);
        chk("rst/m_fmt",       64'(m_out_fmt),   64'd0);
        chk("rst/m_tag",       64'(m_out_tag),   64'd0);
        chk("rst/a_err",       64'(a_out_err),   64'd0);
        chk("rst/m_cnt",       64'(m_err_cnt),   64'd0);
        chk("rst/a_cnt",       64'(a_err_cnt),   64'd0);

        // addi x1,x0,-1 with latency check
        instr = 32'hFFF00093; imm_src = 3'b000; in_tag = 4'd1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lat/m_valid_early", 64'(m_out_valid), 64'd0);
        chk("lat/a_valid_early", 64'(a_out_valid), 64'd0);
        step();
        check_out("addi", 32'hFFFF_FFFF, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 4'd1);

        beat(32'h800002B7, 3'b100, 4'd2);
        check_out("lui", 32'h8000_0000, 3'b100, 64'hFFFF_FFFF_8000_0000, 3'b100, 4'd2);
        beat(32'h03F09093, 3'b110, 4'd3);
        check_out("slli", 32'd31, 3'b110, 64'd63, 3'b110, 4'd3);
        beat(32'h4010D093, 3'b110, 4'd4);
        check_out("srai", 32'd1, 3'b110, 64'd1, 3'b110, 4'd4);
        beat(32'hFE000EE3, 3'b010, 4'd5);
        check_out("beq", 32'hFFFF_FFFC, 3'b010, 64'hFFFF_FFFF_FFFF_FFFC, 3'b010, 4'd5);
        beat(32'hFF9FF0EF, 3'b011, 4'd6);
        check_out("jal", 32'hFFFF_FFF8, 3'b011, 64'hFFFF_FFFF_FFFF_FFF8, 3'b011, 4'd6);
        beat(32'hFE20AA23, 3'b001, 4'd7);
        check_out("sw", 32'hFFFF_FFF4, 3'b001, 64'hFFFF_FFFF_FFFF_FFF4, 3'b001, 4'd7);
        beat(32'h305AD073, 3'b101, 4'd8);
        check_out("csrrwi", 32'h15, 3'b101, 64'h15, 3'b101, 4'd8);
        beat(32'h30509073, 3'b000, 4'd9);
        check_out("csrrw", 32'h305, 3'b000, 64'h305, 3'b000, 4'd9);
        beat(32'h00812083, 3'b000, 4'd10);
        check_out("lw", 32'd8, 3'b000, 64'd8, 3'b000, 4'd10);

        // illegal beats: counter saturates at 3 on the CNT_W=2 instance
        for (int k = 1; k <= 5; k++) begin
            beat(32'h0000_0000, 3'b111, 4'(k));
            check_out($sformatf("ill%0d", k), 32'd0, 3'b111, 64'd0, 3'b111, 4'(k));
            chk($sformatf("ill%0d/a_cnt", k), 64'(a_err_cnt), 64'((k - 1 > 3) ? 3 : k - 1));
            chk($sformatf("ill%0d/m_cnt", k), 64'(m_err_cnt), 64'(k - 1));
        end
        step();
        chk("sat/a_cnt", 64'(a_err_cnt), 64'd3);
        chk("sat/m_cnt", 64'(m_err_cnt), 64'd5);

        // clear wins over a same-cycle illegal transfer
        beat(32'h0000_0000, 3'b111, 4'd9);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("clr/a_cnt",   64'(a_err_cnt),   64'd0);
        chk("clr/m_cnt",   64'(m_err_cnt),   64'd0);
        chk("clr/m_valid", 64'(m_out_valid), 64'd0);
        beat(32'h0000_0000, 3'b111, 4'd10);
        step();
        chk("inc/a_cnt", 64'(a_err_cnt), 64'd1);
        chk("inc/m_cnt", 64'(m_err_cnt), 64'd1);

        // stall: two beats held, then drain four beats in order
        out_ready = 1'b0;
        instr = 32'h00100093; imm_src = 3'b000; in_tag = 4'd1; in_valid = 1'b1;
        step();
        chk("stall/in_ready_open", 64'(m_in_ready), 64'd1);
        instr = 32'h00200093; in_tag = 4'd2;
        step();
        instr = 32'h00300093; in_tag = 4'd3;
        chk("stall/m_in_ready", 64'(m_in_ready), 64'd0);
        chk("stall/a_in_ready", 64'(a_in_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall%0d/m_valid", c), 64'(m_out_valid), 64'd1);
            chk($sformatf("stall%0d/m_tag", c),   64'(m_out_tag),   64'd1);
            chk($sformatf("stall%0d/m_imm", c),   64'(m_imm),       64'd1);
            chk($sformatf("stall%0d/a_imm", c),   a_imm,            64'd1);
            chk($sformatf("stall%0d/in_ready", c), 64'(m_in_ready), 64'd0);
            step();
        end
        exp_q    = '{4'd1, 4'd2, 4'd3, 4'd4};
        next_tag = 3;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            @(negedge clk);
            if (m_out_valid) begin
                chk("drain/m_tag", 64'(m_out_tag), 64'(exp_q[0]));
                chk("drain/m_imm", 64'(m_imm),     64'(exp_q[0]));
                chk("drain/a_tag", 64'(a_out_tag), 64'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            accepted = in_valid && m_in_ready;
            step();
            if (accepted) begin
                if (next_tag == 4) begin
                    in_valid = 1'b0;
                end else begin
                    next_tag++;
                    in_tag = 4'(next_tag);
                    instr  = (32'(next_tag) << 20) | 32'h93;
                end
            end
        end
        chk("drain/left", 64'(exp_q.size()), 64'd0);
        in_valid = 1'b0;
        step();

        // asynchronous reset while stalled with two beats in flight
        out_ready = 1'b0;
        instr = 32'h00500093; in_tag = 4'd5; in_valid = 1'b1;
        step();
        instr = 32'h00600093; in_tag = 4'd6;
        step();
        in_valid = 1'b0;
        chk("arst/pre_valid", 64'(m_out_valid), 64'd1);
        chk("arst/pre_cnt",   64'(m_err_cnt),   64'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst/m_valid", 64'(m_out_valid), 64'd0);
        chk("arst/a_valid", 64'(a_out_valid), 64'd0);
        chk("arst/m_cnt",   64'(m_err_cnt),   64'd0);
        chk("arst/a_cnt",   64'(a_err_cnt),   64'd0);
        chk("arst/a_imm",   a_imm,            64'd0);
        chk("arst/m_tag",   64'(m_out_tag),   64'd0);
        step();
        step();
        rst = 1'b0;
        chk("arst/in_ready", 64'(m_in_ready),  64'd1);
        chk("arst/valid",    64'(m_out_valid), 64'd0);
        out_ready = 1'b1;
        instr = 32'h00700093; imm_src = 3'b000; in_tag = 4'd7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("post/valid_early", 64'(m_out_valid), 64'd0);
        step();
        check_out("post", 32'd7, 3'b000, 64'd7, 3'b000, 4'd7);
        step();
        chk("post/no_ghost", 64'(m_out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
